// File: rtl/axi_2to1_arbiter.sv
// rtl/axi_2to1_arbiter.sv - two-master to one in-order AXI slave arbiter with route FIFOs

// Small in-order FIFO holding the 1-bit master index for each in-flight burst.
module axi_route_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rstnn,
    input  logic clear,
    input  logic push,
    input  logic push_idx,
    input  logic pop,
    output logic head,
    output logic empty,
    output logic full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head    = mem[rd_ptr];
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; clear behaves exactly like reset.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Two-state address-channel arbiter: grant in IDLE, hold until the slave handshake.
module axi_addr_arb (
    input  logic       clk,
    input  logic       rstnn,
    input  logic       clear,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       hs,
    output logic       locked,
    output logic       grant
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t state;
    logic   last_winner;

    assign locked = (state == LOCKED);

    // Grant alternates on contention; last_winner starts at 1 so m0 wins first.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_winner <= 1'b1;
        end else if (clear) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_winner <= 1'b1;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant <= (req == 2'b11) ? ~last_winner : req[1];
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (hs) begin
                        last_winner <= grant;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

module axi_2to1_arbiter #(
    parameter int BW_ADDR           = 32,
    parameter int BW_DATA           = 32,
    parameter int BW_AXI_TID        = 4,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstnn,
    input  logic                  clear,
    input  logic                  enable,
    // master 0
    input  logic [BW_AXI_TID-1:0] m0_arid,
    input  logic [BW_ADDR-1:0]    m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [BW_AXI_TID-1:0] m0_rid,
    output logic [BW_DATA-1:0]    m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [BW_AXI_TID-1:0] m0_awid,
    input  logic [BW_ADDR-1:0]    m0_awaddr,
    input  logic [7:0]            m0_awlen,
    input  logic [2:0]            m0_awsize,
    input  logic [1:0]            m0_awburst,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [BW_DATA-1:0]    m0_wdata,
    input  logic [BW_DATA/8-1:0]  m0_wstrb,
    input  logic                  m0_wlast,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [BW_AXI_TID-1:0] m0_bid,
    output logic [1:0]            m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    // master 1
    input  logic [BW_AXI_TID-1:0] m1_arid,
    input  logic [BW_ADDR-1:0]    m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [BW_AXI_TID-1:0] m1_rid,
    output logic [BW_DATA-1:0]    m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [BW_AXI_TID-1:0] m1_awid,
    input  logic [BW_ADDR-1:0]    m1_awaddr,
    input  logic [7:0]            m1_awlen,
    input  logic [2:0]            m1_awsize,
    input  logic [1:0]            m1_awburst,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [BW_DATA-1:0]    m1_wdata,
    input  logic [BW_DATA/8-1:0]  m1_wstrb,
    input  logic                  m1_wlast,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [BW_AXI_TID-1:0] m1_bid,
    output logic [1:0]            m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    // slave
    output logic [BW_AXI_TID-1:0] s_arid,
    output logic [BW_ADDR-1:0]    s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [BW_AXI_TID-1:0] s_rid,
    input  logic [BW_DATA-1:0]    s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [BW_AXI_TID-1:0] s_awid,
    output logic [BW_ADDR-1:0]    s_awaddr,
    output logic [7:0]            s_awlen,
    output logic [2:0]            s_awsize,
    output logic [1:0]            s_awburst,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [BW_DATA-1:0]    s_wdata,
    output logic [BW_DATA/8-1:0]  s_wstrb,
    output logic                  s_wlast,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [BW_AXI_TID-1:0] s_bid,
    input  logic [1:0]            s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready
);
    logic ar_locked, ar_grant, ar_hs;
    logic aw_locked, aw_grant, aw_hs;
    logic ar_head, ar_empty, ar_full, r_pop;
    logic w_head, w_empty, w_full, w_pop;
    logic b_head, b_empty, b_full, b_pop;
    logic ar_open, aw_open, r_open, w_open, b_open;

    axi_addr_arb u_ar_arb (
        .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
        .req({m1_arvalid, m0_arvalid}), .hs(ar_hs),
        .locked(ar_locked), .grant(ar_grant)
    );

    axi_addr_arb u_aw_arb (
        .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
        .req({m1_awvalid, m0_awvalid}), .hs(aw_hs),
        .locked(aw_locked), .grant(aw_grant)
    );

    axi_route_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_ar_route (
        .clk(clk), .rstnn(rstnn), .clear(clear),
        .push(ar_hs), .push_idx(ar_grant), .pop(r_pop),
        .head(ar_head), .empty(ar_empty), .full(ar_full)
    );

    axi_route_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_w_route (
        .clk(clk), .rstnn(rstnn), .clear(clear),
        .push(aw_hs), .push_idx(aw_grant), .pop(w_pop),
        .head(w_head), .empty(w_empty), .full(w_full)
    );

    axi_route_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_b_route (
        .clk(clk), .rstnn(rstnn), .clear(clear),
        .push(aw_hs), .push_idx(aw_grant), .pop(b_pop),
        .head(b_head), .empty(b_empty), .full(b_full)
    );

    // Each channel is open only while enabled and its route state allows traffic.
    assign ar_open = enable && ar_locked && !ar_full;
    assign aw_open = enable && aw_locked && !w_full && !b_full;
    assign r_open  = enable && !ar_empty;
    assign w_open  = enable && !w_empty;
    assign b_open  = enable && !b_empty;

    // AR: granted master's request straight through to the slave.
    assign s_arid     = ar_grant ? m1_arid    : m0_arid;
    assign s_araddr   = ar_grant ? m1_araddr  : m0_araddr;
    assign s_arlen    = ar_grant ? m1_arlen   : m0_arlen;
    assign s_arsize   = ar_grant ? m1_arsize  : m0_arsize;
    assign s_arburst  = ar_grant ? m1_arburst : m0_arburst;
    assign s_arvalid  = ar_open && (ar_grant ? m1_arvalid : m0_arvalid);
    assign m0_arready = ar_open && !ar_grant && s_arready;
    assign m1_arready = ar_open &&  ar_grant && s_arready;
    assign ar_hs      = s_arvalid && s_arready;

    // R: the oldest outstanding read owns the return path until its last beat.
    assign m0_rid    = s_rid;
    assign m0_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rid    = s_rid;
    assign m1_rdata  = s_rdata;
    assign m1_rresp  = s_rresp;
    assign m1_rlast  = s_rlast;
    assign m0_rvalid = r_open && !ar_head && s_rvalid;
    assign m1_rvalid = r_open &&  ar_head && s_rvalid;
    assign s_rready  = r_open && (ar_head ? m1_rready : m0_rready);
    assign r_pop     = s_rvalid && s_rready && s_rlast;

    // AW: same arbitration as AR; blocked while either write route is full.
    assign s_awid     = aw_grant ? m1_awid    : m0_awid;
    assign s_awaddr   = aw_grant ? m1_awaddr  : m0_awaddr;
    assign s_awlen    = aw_grant ? m1_awlen   : m0_awlen;
    assign s_awsize   = aw_grant ? m1_awsize  : m0_awsize;
    assign s_awburst  = aw_grant ? m1_awburst : m0_awburst;
    assign s_awvalid  = aw_open && (aw_grant ? m1_awvalid : m0_awvalid);
    assign m0_awready = aw_open && !aw_grant && s_awready;
    assign m1_awready = aw_open &&  aw_grant && s_awready;
    assign aw_hs      = s_awvalid && s_awready;

    // W: data only flows for a burst whose AW has already been accepted.
    assign s_wdata   = w_head ? m1_wdata : m0_wdata;
    assign s_wstrb   = w_head ? m1_wstrb : m0_wstrb;
    assign s_wlast   = w_head ? m1_wlast : m0_wlast;
    assign s_wvalid  = w_open && (w_head ? m1_wvalid : m0_wvalid);
    assign m0_wready = w_open && !w_head && s_wready;
    assign m1_wready = w_open &&  w_head && s_wready;
    assign w_pop     = s_wvalid && s_wready && s_wlast;

    // B: one response per write burst, returned in AW order.
    assign m0_bid    = s_bid;
    assign m0_bresp  = s_bresp;
    assign m1_bid    = s_bid;
    assign m1_bresp  = s_bresp;
    assign m0_bvalid = b_open && !b_head && s_bvalid;
    assign m1_bvalid = b_open &&  b_head && s_bvalid;
    assign s_bready  = b_open && (b_head ? m1_bready : m0_bready);
    assign b_pop     = s_bvalid && s_bready;
endmodule

// File: tb/tb_axi_2to1_arbiter.sv
// tb/tb_axi_2to1_arbiter.sv - table-driven and sequence checks for axi_2to1_arbiter
module tb_axi_2to1_arbiter;
    logic clk = 1'b0;
    logic rstnn, clear, enable;

    logic [3:0]  m0_arid, m1_arid, m0_rid, m1_rid, m0_awid, m1_awid, m0_bid, m1_bid;
    logic [31:0] m0_araddr, m1_araddr, m0_awaddr, m1_awaddr;
    logic [7:0]  m0_arlen, m1_arlen, m0_awlen, m1_awlen;
    logic [2:0]  m0_arsize, m1_arsize, m0_awsize, m1_awsize;
    logic [1:0]  m0_arburst, m1_arburst, m0_awburst, m1_awburst;
    logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;
    logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
    logic        m0_awvalid, m1_awvalid, m0_awready, m1_awready;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_wlast, m1_wlast, m0_wvalid, m1_wvalid, m0_wready, m1_wready;
    logic        m0_bvalid, m1_bvalid, m0_bready, m1_bready;

    logic [3:0]  s_arid, s_rid, s_awid, s_bid;
    logic [31:0] s_araddr, s_awaddr, s_rdata, s_wdata;
    logic [7:0]  s_arlen, s_awlen;
    logic [2:0]  s_arsize, s_awsize;
    logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic        s_awvalid, s_awready;
    logic [3:0]  s_wstrb;
    logic        s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_2to1_arbiter dut (
        .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
        .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_awid(m0_awid), .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awsize(m0_awsize),
        .m0_awburst(m0_awburst), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wlast(m0_wlast), .m0_wvalid(m0_wvalid),
        .m0_wready(m0_wready), .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid),
        .m0_bready(m0_bready),
        .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awid(m1_awid), .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
        .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast), .m1_wvalid(m1_wvalid),
        .m1_wready(m1_wready), .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
        .m1_bready(m1_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
        .s_bready(s_bready)
    );

    typedef struct packed {
        logic       m0v, m1v, sar, srv, srl, m0rr, m1rr;
        logic       e_sarv;
        logic [3:0] e_arid;
        logic       e_m0ar, e_m1ar, e_m0rv, e_m1rv, e_srr;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // m0v m1v sar srv srl m0rr m1rr | sarv arid m0ar m1ar m0rv m1rv srr
        vecs[0]  = '{1,1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[1]  = '{1,1,1,0,0,0,0, 1,4'h1,1,0,0,0,0};
        vecs[2]  = '{1,1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[3]  = '{1,1,1,0,0,0,0, 1,4'h2,0,1,0,0,0};
        vecs[4]  = '{0,1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[5]  = '{0,1,0,0,0,0,0, 1,4'h2,0,0,0,0,0};
        vecs[6]  = '{0,1,1,0,0,0,0, 1,4'h2,0,1,0,0,0};
        vecs[7]  = '{1,0,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[8]  = '{1,1,1,0,0,0,0, 1,4'h1,1,0,0,0,0};
        vecs[9]  = '{1,1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[10] = '{1,1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[11] = '{1,1,1,0,0,0,0, 0,4'h0,0,0,0,0,0};
        vecs[12] = '{1,1,1,1,1,1,1, 0,4'h0,0,0,1,0,1};
        vecs[13] = '{1,1,1,0,0,1,1, 1,4'h2,0,1,0,0,1};
        vecs[14] = '{0,0,1,1,0,1,0, 0,4'h0,0,0,0,1,0};
        vecs[15] = '{0,0,1,1,1,1,1, 0,4'h0,0,0,0,1,1};
        vecs[16] = '{0,0,1,1,1,1,1, 0,4'h0,0,0,0,1,1};
        vecs[17] = '{0,0,1,1,1,1,1, 0,4'h0,0,0,1,0,1};
        vecs[18] = '{0,0,1,1,1,1,1, 0,4'h0,0,0,0,1,1};
        vecs[19] = '{0,0,1,1,1,1,1, 0,4'h0,0,0,0,0,0};

        rstnn = 0; clear = 0; enable = 1;
        m0_arid = 4'h1; m0_araddr = 32'h1000; m0_arlen = 8'd3; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_arid = 4'h2; m1_araddr = 32'h2000; m1_arlen = 8'd0; m1_arsize = 3'd2; m1_arburst = 2'd1;
        m0_awid = 4'h3; m0_awaddr = 32'h3000; m0_awlen = 8'd0; m0_awsize = 3'd2; m0_awburst = 2'd1;
        m1_awid = 4'h4; m1_awaddr = 32'h4000; m1_awlen = 8'd1; m1_awsize = 3'd2; m1_awburst = 2'd1;
        m0_arvalid = 1; m1_arvalid = 1; m0_awvalid = 1; m1_awvalid = 0;
        m0_rready = 1; m1_rready = 1; m0_bready = 1; m1_bready = 1;
        m0_wdata = 32'hA0A0_0000; m0_wstrb = 4'hF; m0_wlast = 0; m0_wvalid = 0;
        m1_wdata = 32'hB1B1_0000; m1_wstrb = 4'h3; m1_wlast = 0; m1_wvalid = 0;
        s_arready = 1; s_awready = 1; s_wready = 1;
        s_rid = 4'h0; s_rdata = 32'hDEAD_0000; s_rresp = 2'd0; s_rlast = 1; s_rvalid = 1;
        s_bid = 4'h4; s_bresp = 2'd0; s_bvalid = 1;

        // reset state: every valid/ready output low whatever the inputs
        @(negedge clk); @(negedge clk);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_awvalid", s_awvalid, 0);
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m1_bvalid", m1_bvalid, 0);
        chk("rst_s_bready", s_bready, 0);
        chk("rst_s_wvalid", s_wvalid, 0);
        m0_awvalid = 0; s_rvalid = 0; s_bvalid = 0; m0_rready = 0; m1_rready = 0;
        rstnn = 1;

        // AR arbitration, route fill/back-pressure and R routing
        for (int i = 0; i < 20; i++) begin
            m0_arvalid = vecs[i].m0v; m1_arvalid = vecs[i].m1v; s_arready = vecs[i].sar;
            s_rvalid = vecs[i].srv; s_rlast = vecs[i].srl;
            m0_rready = vecs[i].m0rr; m1_rready = vecs[i].m1rr;
            #1;
            chk($sformatf("v%0d_s_arvalid", i), s_arvalid, vecs[i].e_sarv);
            if (vecs[i].e_sarv) chk($sformatf("v%0d_s_arid", i), s_arid, vecs[i].e_arid);
            chk($sformatf("v%0d_m0_arready", i), m0_arready, vecs[i].e_m0ar);
            chk($sformatf("v%0d_m1_arready", i), m1_arready, vecs[i].e_m1ar);
            chk($sformatf("v%0d_m0_rvalid", i), m0_rvalid, vecs[i].e_m0rv);
            chk($sformatf("v%0d_m1_rvalid", i), m1_rvalid, vecs[i].e_m1rv);
            chk($sformatf("v%0d_s_rready", i), s_rready, vecs[i].e_srr);
            @(negedge clk);
        end
        m0_arvalid = 0; m1_arvalid = 0; s_rvalid = 0;

        clear = 1; @(negedge clk); clear = 0;

        // write ordering: m1 AW then m0 AW, m0 presents data early
        m0_wvalid = 1; m0_wlast = 1; m1_awvalid = 1; s_awready = 1; s_wready = 1;
        #1;
        chk("w0_m0_wready", m0_wready, 0);
        chk("w0_s_wvalid", s_wvalid, 0);
        chk("w0_s_awvalid", s_awvalid, 0);
        @(negedge clk); #1;
        chk("w1_s_awvalid", s_awvalid, 1);
        chk("w1_s_awid", s_awid, 4'h4);
        chk("w1_s_awaddr", s_awaddr, 32'h4000);
        chk("w1_m1_awready", m1_awready, 1);
        chk("w1_m0_awready", m0_awready, 0);
        @(negedge clk);
        m1_awvalid = 0; m0_awvalid = 1; #1;
        chk("w2_s_awvalid", s_awvalid, 0);
        chk("w2_m0_wready", m0_wready, 0);
        chk("w2_s_wvalid", s_wvalid, 0);
        @(negedge clk);
        m1_wvalid = 1; m1_wlast = 0; #1;
        chk("w3_s_awvalid", s_awvalid, 1);
        chk("w3_s_awid", s_awid, 4'h3);
        chk("w3_m0_wready", m0_wready, 0);
        chk("w3_m1_wready", m1_wready, 1);
        chk("w3_s_wdata", s_wdata, 32'hB1B1_0000);
        @(negedge clk);
        m0_awvalid = 0; m1_wlast = 1; #1;
        chk("w4_m0_wready", m0_wready, 0);
        chk("w4_s_wlast", s_wlast, 1);
        chk("w4_m1_wready", m1_wready, 1);
        @(negedge clk);
        m1_wvalid = 0; #1;
        chk("w5_m0_wready", m0_wready, 1);
        chk("w5_s_wvalid", s_wvalid, 1);
        chk("w5_s_wdata", s_wdata, 32'hA0A0_0000);
        chk("w5_m1_wready", m1_wready, 0);
        @(negedge clk); #1;
        chk("w6_s_wvalid", s_wvalid, 0);
        chk("w6_m0_wready", m0_wready, 0);
        @(negedge clk);

        // B responses follow AW order: m1 then m0
        s_bvalid = 1; s_bid = 4'h4; #1;
        chk("b0_m1_bvalid", m1_bvalid, 1);
        chk("b0_m0_bvalid", m0_bvalid, 0);
        chk("b0_s_bready", s_bready, 1);
        chk("b0_m1_bid", m1_bid, 4'h4);
        @(negedge clk);
        s_bid = 4'h3; #1;
        chk("b1_m0_bvalid", m0_bvalid, 1);
        chk("b1_m1_bvalid", m1_bvalid, 0);
        @(negedge clk); #1;
        chk("b2_m0_bvalid", m0_bvalid, 0);
        chk("b2_m1_bvalid", m1_bvalid, 0);
        chk("b2_s_bready", s_bready, 0);
        s_bvalid = 0; m0_wvalid = 0;
        @(negedge clk);

        // enable low holds the grant; reset mid-burst; m0 first after release
        m0_arvalid = 1; s_arready = 1;
        @(negedge clk);
        enable = 0; #1;
        chk("en_s_arvalid", s_arvalid, 0);
        chk("en_m0_arready", m0_arready, 0);
        @(negedge clk);
        enable = 1; #1;
        chk("en_resume_s_arvalid", s_arvalid, 1);
        chk("en_resume_s_arid", s_arid, 4'h1);
        @(negedge clk);
        m0_arvalid = 0; s_rvalid = 1; s_rlast = 0; m0_rready = 1; m1_rready = 1; #1;
        chk("mb1_m0_rvalid", m0_rvalid, 1);
        chk("mb1_m1_rvalid", m1_rvalid, 0);
        @(negedge clk); #1;
        chk("mb2_m0_rvalid", m0_rvalid, 1);
        @(negedge clk);
        rstnn = 0; #1;
        chk("mbrst_m0_rvalid", m0_rvalid, 0);
        chk("mbrst_s_rready", s_rready, 0);
        @(negedge clk);
        rstnn = 1; s_rvalid = 0; m0_arvalid = 1; m1_arvalid = 1; #1;
        chk("post_s_arvalid", s_arvalid, 0);
        @(negedge clk); #1;
        chk("post_grant_s_arvalid", s_arvalid, 1);
        chk("post_grant_s_arid", s_arid, 4'h1);
        chk("post_grant_m0_arready", m0_arready, 1);
        chk("post_grant_m1_arready", m1_arready, 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_2to1_arbiter.md
AXI_2TO1_ARBITER -- requirements
Module: axi_2to1_arbiter

Interface
REQ-001 The block SHALL have parameters BW_ADDR (default 32, address width), BW_DATA (default 32, data width), BW_AXI_TID (default 4, ID width) and OUTSTANDING_DEPTH (default 4, maximum in-flight bursts per direction).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rstnn  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous flush of all route FIFOs and grant state.
REQ-005 enable  input  1  when low, SHALL hold all state and force every valid/ready output low.
REQ-006 m0_/m1_ AR bundle: arid[BW_AXI_TID], araddr[BW_ADDR], arlen, arsize, arburst and arvalid are inputs; arready is an output.
REQ-007 m0_/m1_ R bundle: rid, rdata[BW_DATA], rresp, rlast and rvalid are outputs; rready is an input.
REQ-008 m0_/m1_ AW bundle: awid, awaddr, awlen, awsize, awburst and awvalid are inputs; awready is an output.
REQ-009 m0_/m1_ W bundle: wdata, wstrb[BW_DATA/8], wlast and wvalid are inputs; wready is an output.
REQ-010 m0_/m1_ B bundle: bid, bresp and bvalid are outputs; bready is an input.
REQ-011 The s_ AR/R/AW/W/B bundles SHALL have identical widths and mirrored directions, connecting to one in-order AXI slave.

Function
REQ-012 The AR and AW channels SHALL each have an independent arbiter with states IDLE and LOCKED.
REQ-013 In IDLE with a single arvalid, the arbiter SHALL grant that master; with both asserted, it SHALL grant the master that is not last_ar_winner.
REQ-014 A grant SHALL register on the clock edge and move the arbiter to LOCKED.
REQ-015 In LOCKED, s_ar* SHALL equal the granted master's fields, and s_arvalid SHALL equal the granted arvalid AND NOT ar_route_full.
REQ-016 The granted master's arready SHALL be s_arready AND NOT ar_route_full; the other master's arready SHALL be 0.
REQ-017 The s_AR handshake SHALL push the grant index into ar_route, update last_ar_winner and return the arbiter to IDLE; minimum spacing of s_AR handshakes is therefore 2 cycles.
REQ-018 Grant SHALL NOT change while LOCKED, even if the granted master drops arvalid (protocol violation, no recovery required).
REQ-019 R routing: when ar_route is non-empty, its head index SHALL select which master receives s_r*, gated by s_rvalid; s_rready SHALL equal that master's rready.
REQ-020 When ar_route is empty, s_rready SHALL be 0 and both m_rvalid SHALL be 0.
REQ-021 ar_route SHALL pop on an s_R handshake with rlast=1.
REQ-022 The AW arbiter SHALL mirror REQ-013..018 using last_aw_winner.
REQ-023 An s_AW handshake SHALL push the grant index into both w_route and b_route; s_awvalid SHALL be blocked while either FIFO is full.
REQ-024 W routing: the w_route head SHALL select the master driving s_w*; only that master's wready SHALL equal s_wready; w_route SHALL pop on an s_W handshake with wlast=1.
REQ-025 When w_route is empty, s_wvalid and both m_wready SHALL be 0; write data SHALL never precede its AW.
REQ-026 B routing SHALL follow b_route the same way; b_route SHALL pop on every s_B handshake.
REQ-027 A push and a pop on the same FIFO in the same cycle SHALL both take effect; a full FIFO SHALL accept a push in the same cycle as a pop.
REQ-028 IDs, addresses, len/size/burst, data and responses SHALL pass through unmodified, with zero-cycle combinational paths after grant.

Reset
REQ-029 On rstnn low, all FIFOs SHALL be empty, both arbiters SHALL be IDLE, and last_ar_winner and last_aw_winner SHALL be 1 so that m0 wins first.
REQ-030 During reset, all valid and ready outputs SHALL be 0.
REQ-031 clear SHALL produce the same state as reset on the next edge; in-flight bursts are discarded and this is the caller's responsibility.

Verification
REQ-032 Both masters assert arvalid continuously with s_arready=1 -> s_AR handshakes alternate m0, m1, m0, m1, each 2 cycles apart.
REQ-033 m0 issues AR len=3, then m1 issues AR len=0; slave returns 4+1 beats in order -> m0 receives 4 beats (last on beat 4), then m1 receives 1 beat; the other master's rvalid stays 0 throughout.
REQ-034 OUTSTANDING_DEPTH=4 and five ARs with the slave withholding R -> exactly 4 s_AR handshakes; the fifth is accepted in the cycle after the first rlast handshake.
REQ-035 m1 AW, then m0 AW; m0 asserts wvalid first -> m0 wready=0 until m1's wlast handshake completes; B responses are routed m1 then m0.
REQ-036 Assert rstnn low mid-burst (2 of 4 R beats delivered) -> all valid outputs 0 immediately; after release, a new m0 AR is granted first.
